// File: rtl/hasti_sram_slave_if.sv
// AHB-lite (HASTI) slave-port bundle for a single responder.
//
// Signals (direction as seen by the slave modport):
//   hsel       in   slave select from the bus decoder
//   haddr      in   byte address
//   hwrite     in   1 = write, 0 = read
//   hsize      in   transfer size (0 byte, 1 half, 2 word)
//   hburst     in   burst type (carried for completeness)
//   hprot      in   protection attributes (carried for completeness)
//   htrans     in   IDLE / BUSY / NONSEQ / SEQ
//   hmastlock  in   locked-sequence flag (carried for completeness)
//   hwdata     in   write data, valid in the data phase
//   hready     in   bus-wide ready, previous data phase completing
//   hreadyout  out  this slave's data-phase ready
//   hrdata     out  read data
//   hresp      out  0 = OKAY, 1 = ERROR
interface hasti_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/hasti_sram_slave.sv
// AHB-lite (HASTI) responder backed by a word-organised on-chip SRAM.
//
// Tracks the address/data-phase pipeline, inserts WAIT_STATES wait cycles per
// transfer, performs byte/half/word writes under a lane mask and returns the
// two-cycle ERROR response for illegal sizes or misaligned addresses.
//
// Parameters:
//   AW           word-address bits; depth is 2**AW words of 32 bits (AW <= 29)
//   WAIT_STATES  wait cycles inserted per NONSEQ/SEQ transfer, 0..15
//
// Ports:
//   hclk     in   bus clock, rising-edge
//   hresetn  in   asynchronous active-low reset
//   bus      slave modport of hasti_sram_slave_if (address/data phase signals)
module hasti_sram_slave #(
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic               hclk,
    input logic               hresetn,
    hasti_sram_slave_if.slave bus
);

    localparam logic [3:0] WaitLast = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;   // word index of the data-phase transfer
    logic [1:0]    boff_q,  boff_d;    // byte offset within the word
    logic [1:0]    size_q,  size_d;    // only legal sizes are ever captured
    logic          write_q, write_d;
    logic [3:0]    cnt_q,   cnt_d;

    logic [31:0]   mem [2**AW];

    logic          accept;
    logic          legal;
    logic          can_accept;
    logic          readyout;
    logic          resp;
    logic [3:0]    lane_en;

    // Address phase is taken only for NONSEQ/SEQ; IDLE/BUSY leave us idle,
    // which already gives the zero-wait OKAY response.
    assign accept = bus.hsel & bus.hready & bus.htrans[1];

    always_comb begin
        legal = 1'b0;
        unique case (bus.hsize)
            3'd0:    legal = 1'b1;
            3'd1:    legal = ~bus.haddr[0];
            3'd2:    legal = (bus.haddr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Next state and data-phase outputs.
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        boff_d     = boff_q;
        size_d     = size_q;
        write_d    = write_q;
        cnt_d      = cnt_q;
        readyout   = 1'b1;
        resp       = 1'b0;
        can_accept = 1'b0;

        unique case (state_q)
            StIdle: begin
                can_accept = 1'b1;
            end
            StWait: begin
                readyout = 1'b0;
                if (cnt_q == WaitLast) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StData: begin
                // Completing now, so the concurrent address phase is taken
                // here and back-to-back transfers run without a bubble.
                can_accept = 1'b1;
            end
            StErr1: begin
                readyout = 1'b0;
                resp     = 1'b1;
                state_d  = StErr2;
            end
            StErr2: begin
                resp       = 1'b1;
                can_accept = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (can_accept) begin
            state_d = StIdle;
            if (accept) begin
                waddr_d = bus.haddr[AW+1:2];
                boff_d  = bus.haddr[1:0];
                size_d  = bus.hsize[1:0];
                write_d = bus.hwrite;
                if (!legal) begin
                    state_d = StErr1;
                end else if (WAIT_STATES > 0) begin
                    state_d = StWait;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = StData;
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= StIdle;
            waddr_q <= '0;
            boff_q  <= 2'b00;
            size_q  <= 2'b00;
            write_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            boff_q  <= boff_d;
            size_q  <= size_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    // Byte lanes touched by the captured transfer.
    always_comb begin
        lane_en = 4'b0000;
        unique case (size_q)
            2'd0:    lane_en = 4'b0001 << boff_q;
            2'd1:    lane_en = 4'b0011 << boff_q;
            default: lane_en = 4'b1111;
        endcase
    end

    // Storage is not reset. state_q is forced to StIdle asynchronously, so a
    // reset mid-transfer never reaches StData and never commits a write.
    always_ff @(posedge hclk) begin
        if (state_q == StData && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[waddr_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.hreadyout = readyout;
    assign bus.hresp     = resp;
    assign bus.hrdata    = (state_q == StData && !write_q) ? mem[waddr_q] : 32'h0;

    // Address bits above the memory window alias; burst, protection and lock
    // information has no effect on a simple SRAM.
    logic unused_bus;
    assign unused_bus = ^{bus.haddr[31:AW+2], bus.hburst, bus.hprot, bus.hmastlock,
                          bus.htrans[0], bus.hsize[2]};

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Randomised bench for hasti_sram_slave. Three instances (0, 2 and 3 wait
// states) are exercised one at a time by a pipelined master; every cycle the
// observed response is compared with a transfer-level reference model.
module tb_hasti_sram_slave;

    localparam int unsigned NDUT  = 3;
    localparam int unsigned BAW   = 6;
    localparam int unsigned DEPTH = 64;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
    } op_t;

    logic        hclk = 1'b0;
    logic        hresetn;

    logic        sel_a   [NDUT];
    logic [31:0] addr_a  [NDUT];
    logic        wr_a    [NDUT];
    logic [2:0]  size_a  [NDUT];
    logic [2:0]  burst_a [NDUT];
    logic [3:0]  prot_a  [NDUT];
    logic [1:0]  trans_a [NDUT];
    logic        lock_a  [NDUT];
    logic [31:0] wdata_a [NDUT];
    logic        rdy_a   [NDUT];
    logic        resp_a  [NDUT];
    logic [31:0] rdata_a [NDUT];

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        hasti_sram_slave_if bif ();
        assign bif.hsel      = sel_a[g];
        assign bif.haddr     = addr_a[g];
        assign bif.hwrite    = wr_a[g];
        assign bif.hsize     = size_a[g];
        assign bif.hburst    = burst_a[g];
        assign bif.hprot     = prot_a[g];
        assign bif.htrans    = trans_a[g];
        assign bif.hmastlock = lock_a[g];
        assign bif.hwdata    = wdata_a[g];
        assign bif.hready    = bif.hreadyout;  // sole slave on this bus
        assign rdy_a[g]      = bif.hreadyout;
        assign resp_a[g]     = bif.hresp;
        assign rdata_a[g]    = bif.hrdata;

        hasti_sram_slave #(
            .AW          (BAW),
            .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 2 : 3))
        ) u_dut (
            .hclk    (hclk),
            .hresetn (hresetn),
            .bus     (bif)
        );
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur_dut  = 0;
    logic [31:0] mdl [NDUT][DEPTH];
    op_t         ops [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d got=%08h exp=%08h t=%0t", tag, cur_dut, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic int widx(input bit [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit is_legal(input op_t o);
        if (o.size > 3'd2) return 1'b0;
        return (o.addr % (32'd1 << o.size)) == 0;
    endfunction

    function automatic op_t mk(input bit sel, input bit [1:0] trans, input bit wr,
                               input bit [2:0] size, input bit [31:0] addr, input bit [31:0] wd);
        op_t o;
        o.sel = sel; o.trans = trans; o.wr = wr; o.size = size; o.addr = addr; o.wdata = wd;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  r;
        o.sel   = ($urandom_range(0, 9) != 0);
        o.trans = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        o.wr    = 1'($urandom_range(0, 1));
        r       = int'($urandom_range(0, 19));
        o.size  = (r < 6) ? 3'd0 : (r < 12) ? 3'd1 : (r < 18) ? 3'd2 : 3'($urandom_range(3, 7));
        // 512-byte span covers twice the depth, so aliasing is exercised.
        o.addr  = 32'h2000_0000 + 32'($urandom_range(0, 511));
        if (o.size <= 3'd2 && $urandom_range(0, 4) != 0) o.addr = o.addr & ~((32'd1 << o.size) - 1);
        o.wdata = $urandom;
        return o;
    endfunction

    // Only the bytes named by size and address change.
    task automatic mdl_write(input int d, input op_t o);
        int base = widx(o.addr);
        int off  = int'(o.addr % 4);
        for (int b = 0; b < (1 << o.size); b++) begin
            mdl[d][base][8*(off+b) +: 8] = o.wdata[8*(off+b) +: 8];
        end
    endtask

    task automatic drive(input int d, input op_t a);
        sel_a[d]   = a.sel;
        trans_a[d] = a.trans;
        wr_a[d]    = a.wr;
        size_a[d]  = a.size;
        addr_a[d]  = a.addr;
        burst_a[d] = 3'($urandom);
        prot_a[d]  = 4'($urandom);
        lock_a[d]  = 1'($urandom);
    endtask

    // Pipelined master for instance d. Expected timing: a legal transfer
    // completes WAIT_STATES cycles after its data phase starts, an error
    // takes two cycles, and no data phase means ready OKAY.
    task automatic run_ops(input int d);
        op_t dp;
        op_t a;
        bit  dp_v   = 1'b0;
        bit  dp_err = 1'b0;
        int  cyc    = 0;
        int  i      = 0;
        bit  exp_rdy;
        bit  exp_resp;
        cur_dut = d;
        while (i < ops.size() || dp_v) begin
            @(negedge hclk);
            if (!dp_v) begin
                exp_rdy = 1'b1; exp_resp = 1'b0;
            end else if (dp_err) begin
                exp_rdy = (cyc == 1); exp_resp = 1'b1;
            end else begin
                exp_rdy = (cyc == ws_of(d)); exp_resp = 1'b0;
            end
            check("hreadyout", 32'(rdy_a[d]), 32'(exp_rdy));
            check("hresp", 32'(resp_a[d]), 32'(exp_resp));
            if (dp_v && !dp_err && !dp.wr && exp_rdy) begin
                check("hrdata", rdata_a[d], mdl[d][widx(dp.addr)]);
            end else if (!(dp_v && !dp_err && dp.wr && exp_rdy)) begin
                check("hrdata_zero", rdata_a[d], 32'h0);
            end
            a = (i < ops.size()) ? ops[i] : mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
            drive(d, a);
            wdata_a[d] = dp_v ? dp.wdata : $urandom;
            @(posedge hclk);
            if (exp_rdy) begin
                if (dp_v && !dp_err && dp.wr) mdl_write(d, dp);
                if (i < ops.size()) i++;
                if (a.sel && a.trans[1]) begin
                    dp = a; dp_v = 1'b1; dp_err = !is_legal(a); cyc = 0;
                end else begin
                    dp_v = 1'b0;
                end
            end else begin
                cyc++;
            end
        end
        drive(d, mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0));
    endtask

    initial begin
        op_t o;
        for (int d = 0; d < NDUT; d++) begin
            drive(d, mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0));
            wdata_a[d] = 32'h0;
        end
        hresetn = 1'b1;
        #3 hresetn = 1'b0;
        repeat (2) @(negedge hclk);
        for (int d = 0; d < NDUT; d++) begin
            cur_dut = d;
            check("rst_hreadyout", 32'(rdy_a[d]), 32'd1);
            check("rst_hresp", 32'(resp_a[d]), 32'd0);
            check("rst_hrdata", rdata_a[d], 32'h0);
        end
        hresetn = 1'b1;

        // Fill every word so the model knows all contents.
        for (int d = 0; d < NDUT; d++) begin
            ops.delete();
            for (int w = 0; w < DEPTH; w++)
                ops.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h2000_0000 + 32'(4 * w), $urandom));
            run_ops(d);
        end

        // Write then immediate read, sub-word merges, misaligned error, and
        // transfers that must not be accepted.
        for (int d = 0; d < NDUT; d++) begin
            ops.delete();
            ops.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h2000_0010, 32'hDEAD_BEEF));
            ops.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h2000_0010, 32'h0));
            ops.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h2000_0010, 32'h1122_3344));
            ops.push_back(mk(1'b1, 2'b11, 1'b1, 3'd0, 32'h2000_0013, 32'hAA5A_5A5A));
            ops.push_back(mk(1'b1, 2'b11, 1'b0, 3'd2, 32'h2000_0010, 32'h0));
            ops.push_back(mk(1'b1, 2'b10, 1'b1, 3'd1, 32'h2000_0010, 32'h7777_5566));
            ops.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h2000_0010, 32'h0));
            ops.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h2000_0002, 32'h0BAD_0BAD));
            ops.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h2000_0000, 32'h0));
            ops.push_back(mk(1'b1, 2'b10, 1'b1, 3'd3, 32'h2000_0020, 32'h0BAD_0BAD));
            ops.push_back(mk(1'b1, 2'b00, 1'b1, 3'd2, 32'h2000_0024, 32'h0BAD_0BAD));
            ops.push_back(mk(1'b1, 2'b01, 1'b1, 3'd2, 32'h2000_0024, 32'h0BAD_0BAD));
            ops.push_back(mk(1'b0, 2'b10, 1'b1, 3'd2, 32'h2000_0024, 32'h0BAD_0BAD));
            ops.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h2000_0024, 32'h0));
            ops.push_back(mk(1'b1, 2'b11, 1'b0, 3'd2, 32'h2000_0020, 32'h0));
            // Aliased address: word 0x20000010 seen through wrap.
            ops.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h2000_0110, 32'h0));
            run_ops(d);
        end

        // Reset in the middle of a waited write must abandon it.
        cur_dut = 1;
        o = mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h2000_0014, 32'hCAFE_F00D);
        @(negedge hclk);
        drive(1, o);
        wdata_a[1] = $urandom;
        @(posedge hclk);
        @(negedge hclk);
        drive(1, mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0));
        wdata_a[1] = 32'hCAFE_F00D;
        check("wait_hreadyout", 32'(rdy_a[1]), 32'd0);
        hresetn = 1'b0;
        #1;
        check("midrst_hreadyout", 32'(rdy_a[1]), 32'd1);
        check("midrst_hresp", 32'(resp_a[1]), 32'd0);
        check("midrst_hrdata", rdata_a[1], 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;
        ops.delete();
        ops.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h2000_0014, 32'h0));
        run_ops(1);

        // Random traffic, then a full readback.
        for (int d = 0; d < NDUT; d++) begin
            ops.delete();
            repeat (300) ops.push_back(rand_op());
            run_ops(d);
            ops.delete();
            for (int w = 0; w < DEPTH; w++)
                ops.push_back(mk(1'b1, 2'b11, 1'b0, 3'd2, 32'h2000_0000 + 32'(4 * w), 32'h0));
            run_ops(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
